// File: rtl/serial_mult_ctrl.sv
// Sequencer for the SerialMult shift-add multiplier driving an external MQ right-shift register.
// Define FAST_STEP_EN to merge the add and shift phases into a single STEP state.
module serial_mult_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               mq_load,
  output logic [WIDTH-1:0]   mq_load_value,
  output logic               mq_shift,
  output logic               mq_shift_in,
  input  logic [WIDTH-1:0]   mq_q
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

`ifdef FAST_STEP_EN
  typedef enum logic [2:0] {StIdle, StLoad, StStep, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StShift, StDone} state_e;
`endif

  state_e            state_q;
  logic [WIDTH-1:0]  m_q;
  logic [WIDTH-1:0]  a_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH:0]    sum;
`ifndef FAST_STEP_EN
  logic              c_q;
`endif

  // Conditional add of the multiplicand, one bit wider to keep the carry.
  assign sum = mq_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {1'b0, a_q};

  assign mq_load = (state_q == StLoad);
`ifdef FAST_STEP_EN
  assign mq_shift    = (state_q == StStep);
  assign mq_shift_in = (state_q == StStep) & sum[0];
`else
  assign mq_shift    = (state_q == StShift);
  assign mq_shift_in = (state_q == StShift) & a_q[0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      m_q           <= '0;
      a_q           <= '0;
      count_q       <= '0;
      mq_load_value <= '0;
      product       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifndef FAST_STEP_EN
      c_q           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q           <= multiplicand;
            mq_load_value <= multiplier;
            a_q           <= '0;
            count_q       <= '0;
            busy          <= 1'b1;
`ifndef FAST_STEP_EN
            c_q           <= 1'b0;
`endif
            state_q       <= StLoad;
          end
        end
`ifdef FAST_STEP_EN
        StLoad: state_q <= StStep;
        StStep: begin
          // Add and shift commit together; sum[0] leaves through mq_shift_in.
          a_q     <= sum[WIDTH:1];
          count_q <= count_q + CW'(1);
          state_q <= (count_q == LastStep) ? StDone : StStep;
        end
`else
        StLoad: state_q <= StAdd;
        StAdd: begin
          if (mq_q[0]) {c_q, a_q} <= sum;
          state_q <= StShift;
        end
        StShift: begin
          a_q     <= {c_q, a_q[WIDTH-1:1]};
          c_q     <= 1'b0;
          count_q <= count_q + CW'(1);
          state_q <= (count_q == LastStep) ? StDone : StAdd;
        end
`endif
        StDone: begin
          product <= {a_q, mq_q};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
